// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared constants and types for the Beta fetch stage
package beta_pkg;

  localparam logic [31:0] BETA_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] BETA_ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] BETA_XADR_PC  = 32'h8000_0008;

  // ADD(R31,R31,R31) and BNE(R31,0,XP); the RF stage substitutes these for irin
  localparam logic [31:0] BETA_NOP_INSTR = 32'h83FF_F800;
  localparam logic [31:0] BETA_BNE_INSTR = 32'h77DF_0000;

  typedef enum logic [1:0] {
    IRSRC_IR  = 2'd0,
    IRSRC_BNE = 2'd1,
    IRSRC_NOP = 2'd2
  } irsrc_t;

  typedef enum logic [1:0] {
    PCSEL_SEQ   = 2'd0,
    PCSEL_BR    = 2'd1,
    PCSEL_JMP   = 2'd2,
    PCSEL_ILLOP = 2'd3
  } pcsel_t;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_FULL    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/beta_imem_if.sv
// rtl/beta_imem_if.sv - request/acknowledge bus to the instruction memory
interface beta_imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/beta_pc_next.sv
// rtl/beta_pc_next.sv - redirect/trap target mux with the supervisor-bit rule
module beta_pc_next
  import beta_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = BETA_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = BETA_XADR_PC
) (
  input  pcsel_t      i_pcsel,
  input  logic [31:0] i_c_relative_a,
  input  logic [31:0] i_jt,
  input  logic        i_rf_super,
  output logic [31:0] o_target
);

  logic w_unused_jt_lsb;
  assign w_unused_jt_lsb = ^i_jt[1:0];

  // A sequential pcsel only reaches this mux when a trap is being taken
  always_comb begin
    o_target = XADR_PC;
    case (i_pcsel)
      PCSEL_BR:    o_target = i_c_relative_a;
      PCSEL_JMP:   o_target = {i_jt[31] & i_rf_super, i_jt[30:2], 2'b00};
      PCSEL_ILLOP: o_target = ILLOP_PC;
      default:     o_target = XADR_PC;
    endcase
  end

endmodule

// File: rtl/beta_if.sv
// rtl/beta_if.sv - Beta instruction fetch: PC, imem requests, redirects and trap injection
module beta_if
  import beta_pkg::*;
#(
  parameter logic [31:0] RESET_PC = BETA_RESET_PC,
  parameter logic [31:0] ILLOP_PC = BETA_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = BETA_XADR_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  pcsel,
  input  logic [31:0] cRelativeA,
  input  logic [31:0] jt,
  input  logic        irq,
  beta_imem_if.master imem,
  output logic [31:0] pcin,
  output logic [31:0] irin,
  output logic [1:0]  irsrc
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc, r_pending_pc, r_buf_ir;
  logic         r_rf_super;

  logic         w_ack, w_avail, w_redirect, w_trap, w_jump;
  logic [31:0]  w_target, w_pc_plus4, w_instr;
  irsrc_t       w_irsrc;
  logic         w_req;

  assign w_ack      = imem.imem_ack;
  assign w_avail    = ((r_state == ST_FETCH) && w_ack) || (r_state == ST_FULL);
  assign w_instr    = (r_state == ST_FULL) ? r_buf_ir : imem.imem_rdata;
  assign w_redirect = !stall && (pcsel != 2'd0);
  assign w_trap     = !stall && !w_redirect && w_avail && irq && !r_fetch_pc[31];
  assign w_jump     = w_redirect || w_trap;
  // Supervisor bit is never carried into
  assign w_pc_plus4 = {r_fetch_pc[31], r_fetch_pc[30:0] + 31'd4};

  beta_pc_next #(
    .ILLOP_PC(ILLOP_PC),
    .XADR_PC (XADR_PC)
  ) u_pc_next (
    .i_pcsel       (pcsel_t'(pcsel)),
    .i_c_relative_a(cRelativeA),
    .i_jt          (jt),
    .i_rf_super    (r_rf_super),
    .o_target      (w_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_ack) begin
          if (!w_jump && stall) w_state_nxt = ST_FULL;
        end else if (w_redirect) begin
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_FULL:    if (!stall) w_state_nxt = ST_FETCH;
      ST_DISCARD: if (w_ack)  w_state_nxt = ST_FETCH;
      default:    w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    w_req   = (r_state != ST_FULL);
    w_irsrc = IRSRC_IR;
    if (w_redirect || !w_avail) w_irsrc = IRSRC_NOP;
    else if (w_trap)            w_irsrc = IRSRC_BNE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= 32'd0;
      r_buf_ir     <= 32'd0;
      r_rf_super   <= 1'b1;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_ack) begin
            if (w_jump)     r_fetch_pc <= w_target;
            else if (stall) r_buf_ir   <= imem.imem_rdata;
            else            r_fetch_pc <= w_pc_plus4;
          end else if (w_redirect) begin
            r_pending_pc <= w_target;
          end
        end
        ST_FULL: begin
          if (w_jump)      r_fetch_pc <= w_target;
          else if (!stall) r_fetch_pc <= w_pc_plus4;
        end
        ST_DISCARD: if (w_ack) r_fetch_pc <= r_pending_pc;
        default: ;
      endcase
      if (!stall) r_rf_super <= w_pc_plus4[31];
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = {1'b0, r_fetch_pc[30:2], 2'b00};
  assign pcin           = w_pc_plus4;
  assign irin           = w_instr;
  assign irsrc          = w_irsrc;

endmodule

// File: tb/tb_beta_if.sv
// tb/tb_beta_if.sv - directed self-checking bench for beta_if
module tb_beta_if;
  import beta_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pcsel;
  logic [31:0] c_rel;
  logic [31:0] jt;
  logic        irq;
  logic [31:0] pcin;
  logic [31:0] irin;
  logic [1:0]  irsrc;
  int          checks = 0;
  int          errors = 0;

  beta_imem_if bus();

  beta_if dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .pcsel     (pcsel),
    .cRelativeA(c_rel),
    .jt        (jt),
    .irq       (irq),
    .imem      (bus),
    .pcin      (pcin),
    .irin      (irin),
    .irsrc     (irsrc)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic st, input logic [1:0] ps, input logic ack,
                       input logic [31:0] rdata, input logic iq);
    stall = st;
    pcsel = ps;
    bus.imem_ack = ack;
    bus.imem_rdata = rdata;
    irq = iq;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    c_rel = 32'd0;
    jt = 32'd0;
    drive(1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", bus.imem_addr); end
    checks++; if (irsrc !== 2'd2) begin errors++; $display("FAIL reset_irsrc got %0d exp 2", irsrc); end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 1'b1, 32'hE000_0000 + 32'(4 * i), 1'b0);
      @(negedge clk);
      checks++; if (bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL zw_addr%0d got %h exp %h", i, bus.imem_addr, 32'(4 * i)); end
      checks++; if (pcin !== 32'h8000_0004 + 32'(4 * i)) begin errors++; $display("FAIL zw_pcin%0d got %h exp %h", i, pcin, 32'h8000_0004 + 32'(4 * i)); end
      checks++; if (irsrc !== 2'd0 || irin !== 32'hE000_0000 + 32'(4 * i)) begin errors++; $display("FAIL zw_slot%0d got irsrc %0d irin %h", i, irsrc, irin); end
      tick;
    end
  endtask

  task automatic test_stall;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      checks++; if (irsrc !== 2'd2 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL ws_wait%0d got irsrc %0d req %b exp 2 1", i, irsrc, bus.imem_req); end
      tick;
    end
    drive(1'b1, 2'd0, 1'b1, 32'hE000_0000, 1'b0);
    @(negedge clk);
    checks++; if (irsrc !== 2'd0 || irin !== 32'hE000_0000) begin errors++; $display("FAIL ws_ackstall got irsrc %0d irin %h", irsrc, irin); end
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ws_full_req%0d got %b exp 0", i, bus.imem_req); end
      checks++; if (irin !== 32'hE000_0000) begin errors++; $display("FAIL ws_buf%0d got %h exp e0000000", i, irin); end
      tick;
    end
    drive(1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checks++; if (irsrc !== 2'd0 || irin !== 32'hE000_0000 || pcin !== 32'h8000_0004) begin errors++; $display("FAIL ws_deliver got irsrc %0d irin %h pcin %h", irsrc, irin, pcin); end
    tick;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || irsrc !== 2'd2) begin errors++; $display("FAIL ws_refetch got req %b addr %h irsrc %0d", bus.imem_req, bus.imem_addr, irsrc); end
    tick;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0004, 1'b0);
    @(negedge clk);
    checks++; if (irin !== 32'hE000_0004 || pcin !== 32'h8000_0008 || irsrc !== 2'd0) begin errors++; $display("FAIL ws_next got irin %h pcin %h irsrc %0d", irin, pcin, irsrc); end
    tick;
  endtask

  task automatic test_redirect;
    do_reset;
    c_rel = 32'h8000_0100;
    drive(1'b0, 2'd1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checks++; if (irsrc !== 2'd2) begin errors++; $display("FAIL rd_nop got %0d exp 2", irsrc); end
    tick;
    drive(1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || irsrc !== 2'd2) begin errors++; $display("FAIL rd_discard got req %b addr %h irsrc %0d", bus.imem_req, bus.imem_addr, irsrc); end
    tick;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0000, 1'b0);
    @(negedge clk);
    checks++; if (irsrc !== 2'd2) begin errors++; $display("FAIL rd_stale got irsrc %0d exp 2", irsrc); end
    tick;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0100, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %h exp 00000100", bus.imem_addr); end
    checks++; if (irsrc !== 2'd0 || irin !== 32'hE000_0100 || pcin !== 32'h8000_0104) begin errors++; $display("FAIL rd_target got irsrc %0d irin %h pcin %h", irsrc, irin, pcin); end
    tick;
  endtask

  task automatic to_user_200;
    do_reset;
    jt = 32'h0000_0200;
    drive(1'b0, 2'd2, 1'b1, 32'hE000_0000, 1'b0);
    tick;
  endtask

  task automatic test_jmp;
    to_user_200;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0200, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h200 || pcin !== 32'h0000_0204) begin errors++; $display("FAIL jmp_user_entry got addr %h pcin %h", bus.imem_addr, pcin); end
    tick;
    jt = 32'h8000_0040;
    drive(1'b0, 2'd2, 1'b1, 32'hE000_0204, 1'b0);
    @(negedge clk);
    checks++; if (irsrc !== 2'd2) begin errors++; $display("FAIL jmp_user_nop got %0d exp 2", irsrc); end
    tick;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0040, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h40 || pcin !== 32'h0000_0044) begin errors++; $display("FAIL jmp_user got addr %h pcin %h exp 00000040 00000044", bus.imem_addr, pcin); end
    tick;
    do_reset;
    jt = 32'h8000_0040;
    drive(1'b0, 2'd2, 1'b1, 32'hE000_0000, 1'b0);
    tick;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0040, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h40 || pcin !== 32'h8000_0044) begin errors++; $display("FAIL jmp_super got addr %h pcin %h exp 00000040 80000044", bus.imem_addr, pcin); end
    tick;
  endtask

  task automatic test_trap;
    to_user_200;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0200, 1'b1);
    @(negedge clk);
    checks++; if (irsrc !== 2'd1 || pcin !== 32'h0000_0204) begin errors++; $display("FAIL trap_slot got irsrc %0d pcin %h exp 1 00000204", irsrc, pcin); end
    tick;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0008, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h8 || pcin !== 32'h8000_000C || irsrc !== 2'd0) begin errors++; $display("FAIL trap_xadr got addr %h pcin %h irsrc %0d", bus.imem_addr, pcin, irsrc); end
    tick;
  endtask

  task automatic test_no_trap;
    do_reset;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0000, 1'b1);
    @(negedge clk);
    checks++; if (irsrc !== 2'd0 || pcin !== 32'h8000_0004) begin errors++; $display("FAIL notrap_super got irsrc %0d pcin %h", irsrc, pcin); end
    tick;
    to_user_200;
    drive(1'b0, 2'd3, 1'b1, 32'hE000_0200, 1'b1);
    @(negedge clk);
    checks++; if (irsrc !== 2'd2) begin errors++; $display("FAIL notrap_illop got irsrc %0d exp 2", irsrc); end
    tick;
    drive(1'b0, 2'd0, 1'b1, 32'hE000_0004, 1'b0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h4 || pcin !== 32'h8000_0008 || irsrc !== 2'd0) begin errors++; $display("FAIL notrap_illop_tgt got addr %h pcin %h irsrc %0d", bus.imem_addr, pcin, irsrc); end
    tick;
  endtask

  initial begin
    test_reset;
    test_stall;
    test_redirect;
    test_jmp;
    test_trap;
    test_no_trap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
